pc_fetch_ctrl: RTL and testbench

Multi-cycle instruction-fetch sequencer that owns the program counter register and its next-PC selection.
- Issues one request at a time to instruction memory over a req/gnt + rvalid handshake.
- Presents each fetched instruction and its PC to decode with valid/ready.
- Applies branch/jump redirects from execute, killing any in-flight or held younger fetch.
- Sits between the PC datapath (PC+4 adder, target mux) and the decode stage.

---
 rtl/pc_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time.
// Optional misaligned-redirect trap enabled with MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        kill_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic [31:0] pc_inc_d;
  logic [31:0] tgt_d;
  logic        trap_d;

  assign pc_inc_d = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  assign tgt_d  = redirect_pc;
  assign trap_d = redirect && (redirect_pc[1:0] != 2'b00)
                  && (state_q != HALT);
  assign fetch_misalign = mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (trap_d) begin
      mis_q <= 1'b1;
    end
  end
`else
  logic unused_lo;

  // Targets are forced word-aligned when the trap is not built in
  assign tgt_d          = {redirect_pc[31:2], 2'b00};
  assign trap_d         = 1'b0;
  assign unused_lo      = ^redirect_pc[1:0];
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
    end else if (trap_d) begin
      state_q    <= HALT;
      pc_q       <= tgt_d;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
          if (redirect) pc_q <= tgt_d;
        end
        REQ: begin
          if (redirect) pc_q <= tgt_d;
          if (imem_gnt) begin
            state_q <= WAIT;
            kill_q  <= redirect;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc_q <= tgt_d;
            if (imem_rvalid) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              kill_q <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              if_instr_q <= imem_rdata;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              pc_q       <= pc_inc_d;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          // A redirect flushes the held instruction even if decode is ready
          if (redirect) begin
            pc_q       <= tgt_d;
            if_valid_q <= 1'b0;
            state_q    <= REQ;
          end else if (if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= REQ;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: fetch flow, stalls, redirects, wrap, reset.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_misalign;

  int total = 0;
  int bad   = 0;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    if_ready    = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b1;
    step();
    step();
    total++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_ctl req=%b vld=%b exp 0 0", imem_req, if_valid);
    end
    total++;
    if (imem_addr !== 32'h1000 || if_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_pc addr=%h ifpc=%h exp 1000 0", imem_addr, if_pc);
    end
    total++;
    if (if_instr !== 32'h13 || fetch_misalign !== 1'b0) begin
      bad++;
      $display("FAIL rst_ins ins=%h mis=%b exp 13 0", if_instr, fetch_misalign);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin
      bad++;
      $display("FAIL b_req req=%b addr=%h exp 1 1000", imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL b_wait req=%b exp 0", imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h1000 || if_instr !== 32'h0050_0093) begin
      bad++;
      $display("FAIL b_out v=%b pc=%h ins=%h exp 1 1000 00500093",
               if_valid, if_pc, if_instr);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1004 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL b_next req=%b addr=%h v=%b exp 1 1004 0",
               imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_gnt_stall();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h1004) begin
        bad++;
        $display("FAIL gstall%0d req=%b addr=%h exp 1 1004", i, imem_req, imem_addr);
      end
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL gstall_wait req=%b exp 0", imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_ready_stall();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h1004 ||
          if_instr !== 32'h00A0_0113 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL rstall%0d v=%b pc=%h ins=%h req=%b exp 1 1004 00a00113 0",
                 i, if_valid, if_pc, if_instr, imem_req);
      end
      step();
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1008 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstall_rel req=%b addr=%h v=%b exp 1 1008 0",
               imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_redirect();
    // redirect while waiting; response arrives two cycles later
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h2000;
    step();
    redirect = 1'b0;
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      bad++;
      $display("FAIL rd_wait v=%b req=%b addr=%h exp 0 1 2000",
               if_valid, imem_req, imem_addr);
    end
    // redirect coincident with grant
    imem_gnt    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b0;
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      bad++;
      $display("FAIL rd_gnt v=%b req=%b addr=%h exp 0 1 3000",
               if_valid, imem_req, imem_addr);
    end
    // redirect coincident with rvalid
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h4000;
    step();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4000) begin
      bad++;
      $display("FAIL rd_rv v=%b req=%b addr=%h exp 0 1 4000",
               if_valid, imem_req, imem_addr);
    end
    // redirect in HOLD with a same-cycle ready flushes
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_2222;
    step();
    imem_rvalid = 1'b0;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4000 || if_instr !== 32'h1111_2222) begin
      bad++;
      $display("FAIL rd_hold0 v=%b pc=%h ins=%h exp 1 4000 11112222",
               if_valid, if_pc, if_instr);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h5000;
    if_ready    = 1'b1;
    step();
    redirect = 1'b0;
    if_ready = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h5000) begin
      bad++;
      $display("FAIL rd_hold v=%b req=%b addr=%h exp 0 1 5000",
               if_valid, imem_req, imem_addr);
    end
    // stray rvalid in REQ is ignored
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h5000) begin
      bad++;
      $display("FAIL stray v=%b req=%b addr=%h exp 0 1 5000",
               if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_req req=%b addr=%h exp 1 fffffffc", imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0073;
    step();
    imem_rvalid = 1'b0;
    if_ready    = 1'b1;
    step();
    if_ready = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    reset    = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h1000 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_rst req=%b addr=%h v=%b exp 0 1000 0",
               imem_req, imem_addr, if_valid);
    end
    step();
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    step();
    imem_rvalid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1000) begin
      bad++;
      $display("FAIL rst_resp v=%b req=%b addr=%h exp 0 1 1000",
               if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_misalign();
    redirect    = 1'b1;
    redirect_pc = 32'h2002;
    step();
    redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
    total++;
    if (fetch_misalign !== 1'b1 || imem_addr !== 32'h2002) begin
      bad++;
      $display("FAIL mis_flag mis=%b addr=%h exp 1 2002", fetch_misalign, imem_addr);
    end
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    if_ready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || fetch_misalign !== 1'b1) begin
        bad++;
        $display("FAIL halt%0d req=%b v=%b mis=%b exp 0 0 1",
                 i, imem_req, if_valid, fetch_misalign);
      end
      step();
    end
    idle_in();
`else
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || fetch_misalign !== 1'b0) begin
      bad++;
      $display("FAIL align req=%b addr=%h mis=%b exp 1 2000 0",
               imem_req, imem_addr, fetch_misalign);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_stall();
    test_ready_stall();
    test_redirect();
    test_wrap_and_reset();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
